main_memory_responder: RTL
==========================

Name: main_memory_responder

Overview:
Memory-side responder for the data cache's line-refill path. It accepts a block-read request from the cache controller, waits a fixed access latency, then streams one cache block as consecutive 32-bit beats and signals completion. It models the 32K-word main memory behind the cache, so the cache and its hit/miss bench run against a realistic multi-cycle backing store.

Parameters:
ADDR_W, 15, word-address width (32K words)
DATA_W, 32, word width
BLOCK_WORDS, 4, words per cache block (power of two, >=2)
LATENCY, 8, cycles spent in WAIT before the first beat (>=1)
INIT_PATTERN, 1, 1 = word at address a holds zero-extended a; 0 = all zeros

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
mem_read  input  1  block-read request; sampled only in IDLE
mem_addr  input  ADDR_W  word address of the missing word; sampled with mem_read
mem_busy  output  1  high from the cycle after acceptance through the DONE cycle
mem_valid  output  1  high for exactly one cycle per data beat
mem_beat  output  log2(BLOCK_WORDS)  index of the current beat within the block
mem_data  output  DATA_W  beat data, valid when mem_valid=1
mem_done  output  1  one-cycle pulse after the last beat

Behaviour:
- All outputs registered. Reset values: mem_busy=0, mem_valid=0, mem_beat=0, mem_data=0, mem_done=0; FSM=IDLE; latency counter=0.
- rst has priority over every other event, including mid-WAIT and mid-BURST. The FSM returns to IDLE, no mem_done is emitted, and the aborted transaction is lost.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE: if mem_read=1 at edge T, latch base = mem_addr with the low log2(BLOCK_WORDS) bits cleared, then go to WAIT. mem_busy=1 from T+1.
- WAIT: lasts exactly LATENCY cycles (down-counter loaded with LATENCY-1), then goes to BURST.
- BURST: beat k (k=0..BLOCK_WORDS-1) occurs at cycle T+1+LATENCY+k with mem_valid=1, mem_beat=k, mem_data=mem[base+k]. After the last beat, go to DONE.
- DONE: one cycle, at T+1+LATENCY+BLOCK_WORDS, with mem_done=1, mem_valid=0, mem_busy=1. Next state is IDLE.
- Total occupancy is LATENCY+BLOCK_WORDS+1 cycles. With the defaults, that is 13 busy cycles; a new request is accepted in the following IDLE cycle.
- mem_read and mem_addr are ignored in WAIT, BURST and DONE. No queuing.
- A request held high continuously gives back-to-back transactions, each re-sampling mem_addr in IDLE.
- Address arithmetic: the block is aligned, so base+k never exceeds 2^ADDR_W-1 and no wrap-around is possible. Beat index arithmetic is modulo BLOCK_WORDS.
- mem_data returns to 0 whenever mem_valid=0.
- Storage is read-only in normal operation. Contents are fixed at elaboration by INIT_PATTERN.

Decomposition:
- Shared package cache_pkg: ADDR_W, DATA_W, BLOCK_WORDS, OFFSET_W=log2(BLOCK_WORDS), and the responder state enum {IDLE, WAIT, BURST, DONE}. The cache controller imports the same constants, so block geometry is defined in one place.
- One sub-module: mem_array, a synchronous-read word RAM with a pattern initializer.
- The responder issues each RAM read one cycle ahead of its beat, so that mem_data is registered in the beat cycle.

Test Plan:
1. Defaults; rst released; mem_read=1, mem_addr=15'h0405 at edge T -> mem_busy=1 from T+1. mem_valid=1 at T+9..T+12 with mem_beat 0..3 and mem_data 32'h404, 405, 406, 407. mem_done=1 only at T+13. IDLE at T+14.
2. mem_addr=15'h7FFF -> base 0x7FFC. Data 32'h7FFC..32'h7FFF in order, no wrap to 0.
3. mem_read held high, mem_addr=15'h0010 then 15'h0020 -> first block 0x10..0x13, second accepted at T+14, beats 0x20..0x23 at T+23..T+26. Request ignored during T+1..T+13.
4. During WAIT and BURST, pulse mem_read with mem_addr=15'h1234 -> no effect. The ongoing burst data is unchanged and no extra transaction follows.
5. rst=1 for one cycle at beat 2 -> the next cycle has all outputs 0 and no mem_done. A subsequent request at 15'h0008 completes normally with 0x8..0xB.
6. LATENCY=1, BLOCK_WORDS=8, mem_addr=15'h0043 -> beats at T+2..T+9 with data 0x40..0x47, mem_done at T+10.

Source files
------------

// File: rtl/cache_pkg.sv
// Block geometry and responder state shared by the data cache and its backing memory.
package cache_pkg;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } resp_state_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous-read word store whose contents are a fixed function of the address.
module mem_array #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int INIT_PATTERN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Read-only contents are fully determined at elaboration, so the word is
  // generated from its address instead of being held in an initialised array.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return (INIT_PATTERN != 0) ? DATA_W'(a) : '0;
  endfunction

  // NOTE: only the read register is reset; storage contents never are.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= init_word(rd_addr);
    else            rd_data <= '0;
  end

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory block-read responder: fixed access latency, then one cache block
// streamed as consecutive beats followed by a one-cycle completion pulse.
module main_memory_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W       = cache_pkg::ADDR_W,
  parameter int DATA_W       = cache_pkg::DATA_W,
  parameter int BLOCK_WORDS  = cache_pkg::BLOCK_WORDS,
  parameter int LATENCY      = 8,
  parameter int INIT_PATTERN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_read,
  input  logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_busy,
  output logic                           mem_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] mem_beat,
  output logic [DATA_W-1:0]              mem_data,
  output logic                           mem_done
);

  localparam int                   OFF_W      = $clog2(BLOCK_WORDS);
  localparam int                   CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [OFF_W-1:0]     LAST_BEAT  = OFF_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0]    ALIGN_MASK = ~ADDR_W'(BLOCK_WORDS - 1);

  resp_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic              rd_en;
  logic [OFF_W-1:0]  rd_offset;
  logic [ADDR_W-1:0] rd_addr;

  // RAM reads run one cycle ahead of the beat they feed, so the RAM's read
  // register is the mem_data output register.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_en     = 1'b0;
    rd_offset = '0;
    case (state)
      WAIT:    rd_en = (cnt == '0);
      BURST: begin
        rd_en     = (mem_beat != LAST_BEAT);
        rd_offset = OFF_W'(mem_beat + 1'b1);
      end
      default: rd_en = 1'b0;
    endcase
  end

  assign rd_addr = base | ADDR_W'(rd_offset);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      mem_busy  <= 1'b0;
      mem_valid <= 1'b0;
      mem_beat  <= '0;
      mem_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_done <= 1'b0;
          if (mem_read) begin
            base     <= mem_addr & ALIGN_MASK;
            cnt      <= CNT_W'(LATENCY - 1);
            mem_busy <= 1'b1;
            state    <= WAIT;
          end else begin
            mem_busy <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            mem_valid <= 1'b1;
            mem_beat  <= '0;
            state     <= BURST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BURST: begin
          if (mem_beat == LAST_BEAT) begin
            mem_valid <= 1'b0;
            mem_beat  <= '0;
            mem_done  <= 1'b1;
            state     <= DONE;
          end else begin
            mem_beat <= mem_beat + 1'b1;
          end
        end
        DONE: begin
          mem_done <= 1'b0;
          mem_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .INIT_PATTERN (INIT_PATTERN)
  ) u_mem_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (mem_data)
  );

endmodule
